// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the synchronous RAM.
// Slave modport is the arbiter side; master modport is the requester/RAM side.
interface mem_port_arbiter_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
);
   // Handshake: a requester raises pN_req with we/addr/wdata stable and holds it
   // until it sees the one-cycle pN_gnt pulse, then drops req at the next edge.
   // A read answers with a one-cycle pN_rvalid; pN_rdata holds until the next read.
   logic                 p0_req;
   logic                 p0_we;
   logic [ADDR_BITS-1:0] p0_addr;
   logic [DATA_BITS-1:0] p0_wdata;
   logic                 p0_gnt;
   logic                 p0_rvalid;
   logic [DATA_BITS-1:0] p0_rdata;

   logic                 p1_req;
   logic                 p1_we;
   logic [ADDR_BITS-1:0] p1_addr;
   logic [DATA_BITS-1:0] p1_wdata;
   logic                 p1_gnt;
   logic                 p1_rvalid;
   logic [DATA_BITS-1:0] p1_rdata;

   logic                 rd_ram_en;
   logic [ADDR_BITS-1:0] rd_ram_addr;
   logic [DATA_BITS-1:0] rd_ram_data;
   logic                 wr_ram_en;
   logic [ADDR_BITS-1:0] wr_ram_addr;
   logic [DATA_BITS-1:0] wr_ram_data;
   logic                 busy;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      input  rd_ram_data,
      output p0_gnt, p0_rvalid, p0_rdata,
      output p1_gnt, p1_rvalid, p1_rdata,
      output rd_ram_en, rd_ram_addr,
      output wr_ram_en, wr_ram_addr, wr_ram_data,
      output busy
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      output rd_ram_data,
      input  p0_gnt, p0_rvalid, p0_rdata,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  rd_ram_en, rd_ram_addr,
      input  wr_ram_en, wr_ram_addr, wr_ram_data,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single synchronous RAM; all outputs registered.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed port-0 priority.
module mem_port_arbiter #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_port_arbiter_if.slave    bus,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ACCESS     = 2'd1,
      READ_DATA  = 2'd2,
      WRITE_DONE = 2'd3
   } state_t;

   state_t state, next_state;

   logic                 any_req;
   logic                 grant;
   logic                 win;
   logic                 win_we;
   logic [ADDR_BITS-1:0] win_addr;
   logic [DATA_BITS-1:0] win_wdata;
   logic                 cmd_port;
   logic                 cmd_we;

   logic                 p0_gnt_d, p1_gnt_d;
   logic                 p0_rvalid_d, p1_rvalid_d;
   logic                 rd_en_d, wr_en_d;
   logic [ADDR_BITS-1:0] rd_addr_d, wr_addr_d;
   logic [DATA_BITS-1:0] wr_data_d;
   logic                 busy_d;

   assign state_dbg = state;

   // Arbitration also runs at the closing edge of READ_DATA/WRITE_DONE for 2-cycle throughput.
   assign any_req = bus.p0_req | bus.p1_req;
   assign grant   = (state != ACCESS) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_grant;

   assign win = (bus.p0_req && bus.p1_req) ? ~last_grant : bus.p1_req;

   // Reset value 1 makes port 0 the first winner of a tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      last_grant <= 1'b1;
      else if (grant) last_grant <= win;
   end
`else
   assign win = ~bus.p0_req;
`endif

   assign win_we    = win ? bus.p1_we    : bus.p0_we;
   assign win_addr  = win ? bus.p1_addr  : bus.p0_addr;
   assign win_wdata = win ? bus.p1_wdata : bus.p0_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cmd_port <= 1'b0;
         cmd_we   <= 1'b0;
      end else begin
         state <= next_state;
         if (grant) begin
            cmd_port <= win;
            cmd_we   <= win_we;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:       next_state = grant ? ACCESS : IDLE;
         ACCESS:     next_state = cmd_we ? WRITE_DONE : READ_DATA;
         READ_DATA,
         WRITE_DONE: next_state = grant ? ACCESS : IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_comb begin
      p0_gnt_d    = grant && !win;
      p1_gnt_d    = grant && win;
      rd_en_d     = grant && !win_we;
      wr_en_d     = grant && win_we;
      rd_addr_d   = rd_en_d ? win_addr : '0;
      wr_addr_d   = wr_en_d ? win_addr : '0;
      wr_data_d   = wr_en_d ? win_wdata : '0;
      p0_rvalid_d = (state == READ_DATA) && !cmd_port;
      p1_rvalid_d = (state == READ_DATA) && cmd_port;
      busy_d      = (next_state != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.p0_gnt      <= 1'b0;
         bus.p1_gnt      <= 1'b0;
         bus.p0_rvalid   <= 1'b0;
         bus.p1_rvalid   <= 1'b0;
         bus.p0_rdata    <= '0;
         bus.p1_rdata    <= '0;
         bus.rd_ram_en   <= 1'b0;
         bus.rd_ram_addr <= '0;
         bus.wr_ram_en   <= 1'b0;
         bus.wr_ram_addr <= '0;
         bus.wr_ram_data <= '0;
         bus.busy        <= 1'b0;
      end else begin
         bus.p0_gnt      <= p0_gnt_d;
         bus.p1_gnt      <= p1_gnt_d;
         bus.p0_rvalid   <= p0_rvalid_d;
         bus.p1_rvalid   <= p1_rvalid_d;
         bus.rd_ram_en   <= rd_en_d;
         bus.rd_ram_addr <= rd_addr_d;
         bus.wr_ram_en   <= wr_en_d;
         bus.wr_ram_addr <= wr_addr_d;
         bus.wr_ram_data <= wr_data_d;
         bus.busy        <= busy_d;
         if (p0_rvalid_d) bus.p0_rdata <= bus.rd_ram_data;
         if (p1_rvalid_d) bus.p1_rdata <= bus.rd_ram_data;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
// Cycle N is observed at the falling edge after the Nth rising edge following request setup.
module tb_mem_port_arbiter;

   logic       clk;
   logic       reset;
   logic [1:0] state_dbg;
   logic [7:0] ram [256];
   int         n_checks;
   int         n_pass;

   mem_port_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8)) bus ();

   mem_port_arbiter #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.rd_ram_en) bus.rd_ram_data <= ram[bus.rd_ram_addr];
      if (bus.wr_ram_en) ram[bus.wr_ram_addr] = bus.wr_ram_data;
   end

   function automatic logic [46:0] all_outs();
      return {bus.p0_gnt, bus.p0_rvalid, bus.p0_rdata, bus.p1_gnt, bus.p1_rvalid, bus.p1_rdata,
              bus.rd_ram_en, bus.rd_ram_addr, bus.wr_ram_en, bus.wr_ram_addr, bus.wr_ram_data,
              bus.busy};
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic req0(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
   endtask

   task automatic req1(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      n_checks++;
      if (all_outs() !== 47'd0) $display("FAIL reset_outputs: got %h expected %h", all_outs(), 47'd0);
      else n_pass++;
      n_checks++;
      if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg);
      else n_pass++;
      reset = 1'b0;
      cyc();
      n_checks++;
      if (all_outs() !== 47'd0) $display("FAIL idle_after_reset: got %h expected %h", all_outs(), 47'd0);
      else n_pass++;
   endtask

   task automatic test_p0_read();
      req0(1'b0, 8'h10, 8'h00);
      cyc();
      n_checks++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.rd_ram_en, bus.rd_ram_addr, bus.wr_ram_en, bus.busy} !== {1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1})
         $display("FAIL p0_read_c1: got %b_%b_%b_%h_%b_%b expected 1_0_1_10_0_1", bus.p0_gnt, bus.p1_gnt,
                  bus.rd_ram_en, bus.rd_ram_addr, bus.wr_ram_en, bus.busy);
      else n_pass++;
      bus.p0_req = 1'b0;
      bus.p0_addr = 8'hEE;
      cyc();
      n_checks++;
      if ({bus.p0_gnt, bus.rd_ram_en, bus.rd_ram_addr, bus.busy, bus.p0_rvalid} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0})
         $display("FAIL p0_read_c2: got %b_%b_%h_%b_%b expected 0_0_00_1_0", bus.p0_gnt, bus.rd_ram_en,
                  bus.rd_ram_addr, bus.busy, bus.p0_rvalid);
      else n_pass++;
      cyc();
      n_checks++;
      if ({bus.p0_rvalid, bus.p0_rdata, bus.busy, bus.p1_rvalid} !== {1'b1, 8'hA5, 1'b0, 1'b0})
         $display("FAIL p0_read_c3: got %b_%h_%b_%b expected 1_a5_0_0", bus.p0_rvalid, bus.p0_rdata, bus.busy, bus.p1_rvalid);
      else n_pass++;
      cyc();
      n_checks++;
      if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b0, 8'hA5})
         $display("FAIL p0_rdata_hold: got %b_%h expected 0_a5", bus.p0_rvalid, bus.p0_rdata);
      else n_pass++;
   endtask

   task automatic test_write_then_read();
      logic p1_rv_seen;
      p1_rv_seen = 1'b0;
      req1(1'b1, 8'h20, 8'h3C);
      cyc();
      n_checks++;
      if ({bus.p1_gnt, bus.p0_gnt, bus.wr_ram_en, bus.wr_ram_addr, bus.wr_ram_data, bus.rd_ram_en} !== {1'b1, 1'b0, 1'b1, 8'h20, 8'h3C, 1'b0})
         $display("FAIL p1_write_c1: got %b_%b_%b_%h_%h_%b expected 1_0_1_20_3c_0", bus.p1_gnt, bus.p0_gnt,
                  bus.wr_ram_en, bus.wr_ram_addr, bus.wr_ram_data, bus.rd_ram_en);
      else n_pass++;
      bus.p1_req = 1'b0;
      bus.p1_wdata = 8'hFF;
      cyc();
      p1_rv_seen |= bus.p1_rvalid;
      n_checks++;
      if ({bus.wr_ram_en, bus.wr_ram_addr, bus.wr_ram_data, bus.busy} !== {1'b0, 8'h00, 8'h00, 1'b1})
         $display("FAIL p1_write_c2: got %b_%h_%h_%b expected 0_00_00_1", bus.wr_ram_en, bus.wr_ram_addr,
                  bus.wr_ram_data, bus.busy);
      else n_pass++;
      cyc();
      p1_rv_seen |= bus.p1_rvalid;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL p1_write_c3_busy: got %b expected 0", bus.busy);
      else n_pass++;
      req0(1'b0, 8'h20, 8'h00);
      cyc();
      p1_rv_seen |= bus.p1_rvalid;
      bus.p0_req = 1'b0;
      cyc();
      p1_rv_seen |= bus.p1_rvalid;
      cyc();
      p1_rv_seen |= bus.p1_rvalid;
      n_checks++;
      if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b1, 8'h3C})
         $display("FAIL readback_0x20: got %b_%h expected 1_3c", bus.p0_rvalid, bus.p0_rdata);
      else n_pass++;
      n_checks++;
      if ({p1_rv_seen, bus.p1_rdata} !== {1'b0, 8'h00})
         $display("FAIL p1_untouched: got %b_%h expected 0_00", p1_rv_seen, bus.p1_rdata);
      else n_pass++;
      cyc();
   endtask

   task automatic test_simultaneous();
      int g0;
      int g1;
      pulse_reset();
      req0(1'b0, 8'h00, 8'h00);
      req1(1'b0, 8'h01, 8'h00);
      cyc();
      n_checks++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.rd_ram_addr} !== {1'b1, 1'b0, 8'h00})
         $display("FAIL tie_first_p0: got %b_%b_%h expected 1_0_00", bus.p0_gnt, bus.p1_gnt, bus.rd_ram_addr);
      else n_pass++;
      bus.p0_req = 1'b0;
      cyc();
      cyc();
      n_checks++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.rd_ram_addr, bus.p0_rvalid, bus.p0_rdata} !== {1'b0, 1'b1, 8'h01, 1'b1, 8'h11})
         $display("FAIL tie_then_p1: got %b_%b_%h_%b_%h expected 0_1_01_1_11", bus.p0_gnt, bus.p1_gnt,
                  bus.rd_ram_addr, bus.p0_rvalid, bus.p0_rdata);
      else n_pass++;
      bus.p1_req = 1'b0;
      cyc();
      cyc();
      n_checks++;
      if ({bus.p1_rvalid, bus.p1_rdata} !== {1'b1, 8'h22})
         $display("FAIL p1_read_data: got %b_%h expected 1_22", bus.p1_rvalid, bus.p1_rdata);
      else n_pass++;
      bus.p0_req = 1'b1;
      bus.p1_req = 1'b1;
      g0 = 0;
      g1 = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 16; k++) begin
         cyc();
         n_checks++;
         if ((k % 2) == 1) begin
            if ({bus.p0_gnt, bus.p1_gnt} !== 2'b00)
               $display("FAIL rr_gap_%0d: got %b expected 00", k, {bus.p0_gnt, bus.p1_gnt});
            else n_pass++;
         end else if ((k % 4) == 0) begin
            if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10)
               $display("FAIL rr_grant_%0d: got %b expected 10", k, {bus.p0_gnt, bus.p1_gnt});
            else n_pass++;
         end else begin
            if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01)
               $display("FAIL rr_grant_%0d: got %b expected 01", k, {bus.p0_gnt, bus.p1_gnt});
            else n_pass++;
         end
      end
`else
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (bus.p0_gnt === 1'b1) g0++;
         if (bus.p1_gnt === 1'b1) g1++;
      end
      n_checks++;
      if (g0 !== 5) $display("FAIL starve_p0_grants: got %0d expected 5", g0);
      else n_pass++;
      n_checks++;
      if (g1 !== 0) $display("FAIL starve_p1_grants: got %0d expected 0", g1);
      else n_pass++;
`endif
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      for (int k = 0; k < 4; k++) cyc();
   endtask

   task automatic test_reset_mid_read();
      logic rv_seen;
      rv_seen = 1'b0;
      req0(1'b0, 8'h10, 8'h00);
      cyc();
      bus.p0_req = 1'b0;
      cyc();
      reset = 1'b1;
      #1;
      n_checks++;
      if (all_outs() !== 47'd0) $display("FAIL mid_reset_outputs: got %h expected %h", all_outs(), 47'd0);
      else n_pass++;
      n_checks++;
      if (state_dbg !== 2'd0) $display("FAIL mid_reset_state: got %0d expected 0", state_dbg);
      else n_pass++;
      cyc();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         rv_seen |= bus.p0_rvalid;
      end
      n_checks++;
      if (rv_seen !== 1'b0) $display("FAIL mid_reset_no_rvalid: got %b expected 0", rv_seen);
      else n_pass++;
      req0(1'b0, 8'h10, 8'h00);
      cyc();
      bus.p0_req = 1'b0;
      cyc();
      cyc();
      n_checks++;
      if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b1, 8'hA5})
         $display("FAIL post_reset_read: got %b_%h expected 1_a5", bus.p0_rvalid, bus.p0_rdata);
      else n_pass++;
      cyc();
   endtask

   task automatic test_back_to_back();
      req0(1'b0, 8'h00, 8'h00);
      cyc();
      n_checks++;
      if ({bus.p0_gnt, bus.rd_ram_addr} !== {1'b1, 8'h00})
         $display("FAIL b2b_gnt1: got %b_%h expected 1_00", bus.p0_gnt, bus.rd_ram_addr);
      else n_pass++;
      bus.p0_req = 1'b0;
      cyc();
      req0(1'b0, 8'h01, 8'h00);
      cyc();
      n_checks++;
      if ({bus.p0_gnt, bus.rd_ram_addr, bus.p0_rvalid, bus.p0_rdata} !== {1'b1, 8'h01, 1'b1, 8'h11})
         $display("FAIL b2b_c3: got %b_%h_%b_%h expected 1_01_1_11", bus.p0_gnt, bus.rd_ram_addr,
                  bus.p0_rvalid, bus.p0_rdata);
      else n_pass++;
      bus.p0_req = 1'b0;
      cyc();
      n_checks++;
      if ({bus.p0_gnt, bus.p0_rvalid, bus.busy} !== {1'b0, 1'b0, 1'b1})
         $display("FAIL b2b_c4: got %b_%b_%b expected 0_0_1", bus.p0_gnt, bus.p0_rvalid, bus.busy);
      else n_pass++;
      cyc();
      n_checks++;
      if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b1, 8'h22})
         $display("FAIL b2b_c5: got %b_%h expected 1_22", bus.p0_rvalid, bus.p0_rdata);
      else n_pass++;
      cyc();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      ram[8'h00] = 8'h11;
      ram[8'h01] = 8'h22;
      ram[8'h10] = 8'hA5;
      reset = 1'b1;
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 8'h00; bus.p0_wdata = 8'h00;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 8'h00; bus.p1_wdata = 8'h00;

      test_reset();
      test_p0_read();
      test_write_then_read();
      test_simultaneous();
      test_reset_mid_read();
      test_back_to_back();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
